// File: rtl/calc1_pkg.sv
// Shared types for the calc1 ALU path: command/state encodings, request and
// result structs, and the combinational execute function.
package calc1_pkg;

  localparam int NUM_PORTS = 4;
  localparam int ID_W      = $clog2(NUM_PORTS);
  localparam int CMD_W     = 4;
  localparam int DATA_W    = 32;

  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'b0110;

  typedef enum logic [1:0] {
    PORT_IDLE = 2'b00,
    PORT_OP2  = 2'b01,
    PORT_PEND = 2'b10
  } port_state_e;

  // Response classes as seen by the output stage.
  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_OVF  = 2'b10,
    RESP_ERR  = 2'b11
  } resp_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } port_req_t;

  typedef struct packed {
    logic              ovf;
    logic              err;
    logic [DATA_W-1:0] data;
  } exec_res_t;

  function automatic exec_res_t alu_exec(port_req_t r);
    logic [DATA_W:0] sum;
    alu_exec = '0;
    sum      = {1'b0, r.op1} + {1'b0, r.op2};
    case (r.cmd)
      CMD_ADD: if (sum[DATA_W]) begin
                 alu_exec.ovf = 1'b1;
                 alu_exec.err = 1'b1;
               end else alu_exec.data = sum[DATA_W-1:0];
      CMD_SUB: if (r.op2 > r.op1) begin
                 alu_exec.ovf = 1'b1;
                 alu_exec.err = 1'b1;
               end else alu_exec.data = r.op1 - r.op2;
      CMD_SHL: alu_exec.data = r.op1 << r.op2[4:0];
      CMD_SHR: alu_exec.data = r.op1 >> r.op2[4:0];
      default: alu_exec.err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Requester ports and result bus of the calc1 issue stage.
interface alu_issue_stage_if;
  logic [0:3]  req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in;
  logic [0:31] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic        req1_busy,    req2_busy,    req3_busy,    req4_busy;
  logic [0:63] alu_result;
  logic        alu_overflow;
  logic        local_error_found;
  logic [1:0]  prio_alu_out_req_id;
  logic        prio_alu_out_vld;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  req1_busy, req2_busy, req3_busy, req4_busy,
    input  alu_result, alu_overflow, local_error_found,
    input  prio_alu_out_req_id, prio_alu_out_vld
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output req1_busy, req2_busy, req3_busy, req4_busy,
    output alu_result, alu_overflow, local_error_found,
    output prio_alu_out_req_id, prio_alu_out_vld
  );
endinterface

// File: rtl/alu_port_capture.sv
// One requester port: captures cmd+op1 then op2, and holds the command until granted.
module alu_port_capture
  import calc1_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output logic              pend,
  output logic              busy,
  output port_req_t         req
);

  port_state_e state, state_nxt;
  logic        gnt_q;
  logic        capture;

  // gnt_q keeps the port busy while its result sits on the output bus.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      PORT_IDLE: if (cmd != '0 && !gnt_q) begin
                   capture   = 1'b1;
                   state_nxt = PORT_OP2;
                 end
      PORT_OP2:  state_nxt = PORT_PEND;
      PORT_PEND: if (grant) state_nxt = PORT_IDLE;
      default:   state_nxt = PORT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PORT_IDLE;
      gnt_q <= 1'b0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      gnt_q <= grant;
      if (capture) begin
        req.cmd <= cmd;
        req.op1 <= data;
      end
      if (state == PORT_OP2) req.op2 <= data;
    end
  end

  assign pend = (state == PORT_PEND);
  assign busy = (state != PORT_IDLE) || gnt_q;

endmodule

// File: rtl/alu_issue_stage.sv
// calc1 ALU front end: four capture ports, round-robin grant, execute and
// registered result bus toward the output stage.
module alu_issue_stage
  import calc1_pkg::*;
#(
  parameter int RR_RESET_PTR = 0
) (
  input  logic               c_clk,
  input  logic               reset,
  alu_issue_stage_if.slave   bus
);

  logic [NUM_PORTS-1:0][CMD_W-1:0]  cmd;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data;
  logic [NUM_PORTS-1:0]             pend, busy, grant;
  port_req_t                        req [NUM_PORTS];

  logic [ID_W-1:0] rr_ptr, gnt_idx;
  logic            gnt_any;
  exec_res_t       res;

  logic [63:0]     result_q;
  logic            ovf_q, err_q, vld_q;
  logic [ID_W-1:0] id_q;

  assign cmd[0]  = bus.req1_cmd_in;   assign data[0] = bus.req1_data_in;
  assign cmd[1]  = bus.req2_cmd_in;   assign data[1] = bus.req2_data_in;
  assign cmd[2]  = bus.req3_cmd_in;   assign data[2] = bus.req3_data_in;
  assign cmd[3]  = bus.req4_cmd_in;   assign data[3] = bus.req4_data_in;
  assign bus.req1_busy = busy[0];
  assign bus.req2_busy = busy[1];
  assign bus.req3_busy = busy[2];
  assign bus.req4_busy = busy[3];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    alu_port_capture u_port (
      .clk   (c_clk),
      .rst_n (reset),
      .cmd   (cmd[g]),
      .data  (data[g]),
      .grant (grant[g]),
      .pend  (pend[g]),
      .busy  (busy[g]),
      .req   (req[g])
    );
  end

  // First PEND port found walking upward from rr_ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_any && pend[rr_ptr + ID_W'(i)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_ptr + ID_W'(i);
      end
    end
    grant = '0;
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign res = alu_exec(req[gnt_idx]);

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= ID_W'(RR_RESET_PTR);
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      if (gnt_any) rr_ptr <= gnt_idx + 1'b1;
      vld_q    <= gnt_any;
      id_q     <= gnt_any ? gnt_idx : '0;
      ovf_q    <= gnt_any & res.ovf;
      err_q    <= gnt_any & res.err;
      result_q <= gnt_any ? {31'b0, res.err, res.data} : '0;
    end
  end

  assign bus.alu_result          = result_q;
  assign bus.alu_overflow        = ovf_q;
  assign bus.local_error_found   = err_q;
  assign bus.prio_alu_out_req_id = id_q;
  assign bus.prio_alu_out_vld    = vld_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios against hand-derived values and a
// randomized run against an occupancy/queue reference model.
module tb_alu_issue_stage;
  import calc1_pkg::*;

  logic c_clk = 1'b0;
  logic reset = 1'b0;
  always #5 c_clk = ~c_clk;

  alu_issue_stage_if bus();

  alu_issue_stage #(.RR_RESET_PTR(0)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0]  tb_cmd  [4];
  logic [31:0] tb_data [4];
  assign bus.req1_cmd_in = tb_cmd[0];  assign bus.req1_data_in = tb_data[0];
  assign bus.req2_cmd_in = tb_cmd[1];  assign bus.req2_data_in = tb_data[1];
  assign bus.req3_cmd_in = tb_cmd[2];  assign bus.req3_data_in = tb_data[2];
  assign bus.req4_cmd_in = tb_cmd[3];  assign bus.req4_data_in = tb_data[3];

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // Each port either holds a command (with or without its second operand) or is
  // free; "cool" marks a port whose result is on the bus this cycle.
  function automatic logic [33:0] ref_exec(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    logic [63:0] s;
    s = 64'(a) + 64'(b);
    case (c)
      4'd1: ref_exec = (s > 64'hFFFF_FFFF) ? {2'b11, 32'd0} : {2'b00, s[31:0]};
      4'd2: ref_exec = (b > a) ? {2'b11, 32'd0} : {2'b00, a - b};
      4'd5: ref_exec = {2'b00, a << (b % 32)};
      4'd6: ref_exec = {2'b00, a >> (b % 32)};
      default: ref_exec = {2'b01, 32'd0};
    endcase
  endfunction

  logic        m_has [4], m_ready [4], m_cool [4];
  logic [3:0]  m_cmd [4];
  logic [31:0] m_op1 [4], m_op2 [4];
  int          m_ptr;
  int          m_g;
  logic [33:0] m_r;
  logic        e_vld, e_err, e_ovf;
  logic [1:0]  e_id;
  logic [31:0] e_data;

  always_comb begin
    m_g = -1;
    for (int k = 0; k < 4; k++)
      if (m_g < 0 && m_has[(m_ptr + k) % 4] && m_ready[(m_ptr + k) % 4]) m_g = (m_ptr + k) % 4;
  end

  always_comb begin
    m_r = '0;
    if (m_g >= 0) m_r = ref_exec(m_cmd[m_g], m_op1[m_g], m_op2[m_g]);
  end

  always @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_has[i] <= 1'b0; m_ready[i] <= 1'b0; m_cool[i] <= 1'b0;
      end
      m_ptr <= 0;
      e_vld <= 1'b0; e_id <= 2'd0; e_data <= '0; e_err <= 1'b0; e_ovf <= 1'b0;
    end else begin
      e_vld <= (m_g >= 0);
      e_id  <= (m_g >= 0) ? 2'(m_g) : 2'd0;
      {e_ovf, e_err, e_data} <= (m_g >= 0) ? m_r : '0;
      if (m_g >= 0) m_ptr <= (m_g + 1) % 4;
      for (int i = 0; i < 4; i++) begin
        m_cool[i] <= (m_g == i);
        if (m_g == i) m_has[i] <= 1'b0;
        else if (!m_has[i] && !m_cool[i] && tb_cmd[i] != 4'd0) begin
          m_has[i] <= 1'b1; m_ready[i] <= 1'b0; m_cmd[i] <= tb_cmd[i]; m_op1[i] <= tb_data[i];
        end else if (m_has[i] && !m_ready[i]) begin
          m_op2[i] <= tb_data[i]; m_ready[i] <= 1'b1;
        end
      end
    end
  end

  wire [3:0]  busy_v = {bus.req4_busy, bus.req3_busy, bus.req2_busy, bus.req1_busy};
  wire [72:0] obs    = {bus.prio_alu_out_vld, bus.prio_alu_out_req_id, bus.alu_result,
                        bus.alu_overflow, bus.local_error_found, busy_v};
  logic [72:0] expv;
  always_comb expv = {e_vld, e_id, 31'b0, e_err, e_data, e_ovf, e_err,
                      m_has[3] | m_cool[3], m_has[2] | m_cool[2],
                      m_has[1] | m_cool[1], m_has[0] | m_cool[0]};

  // Result-bus fields as one vector: {vld, id, result, ovf, err}.
  wire [68:0] res_v = {bus.prio_alu_out_vld, bus.prio_alu_out_req_id, bus.alu_result,
                       bus.alu_overflow, bus.local_error_found};

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge c_clk);
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin tb_cmd[i] = 4'd0; tb_data[i] = '0; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_all();
    cyc(); cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_all();
    cyc();
    n_cmp++;
    if (res_v !== 69'd0 || busy_v !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state got %h busy %b want 0", res_v, busy_v);
    end
    reset = 1'b1;
    cyc();
    n_cmp++;
    if (res_v !== 69'd0 || busy_v !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release got %h busy %b want 0", res_v, busy_v);
    end
  endtask

  // One uncontended command; checks the result two cycles after the command
  // edge and that busy drops the cycle after vld.
  task automatic single_op(input int p, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] xd,
                           input logic xe, input logic xo, input string nm);
    logic [68:0] want;
    tb_cmd[p] = c;    tb_data[p] = a; cyc();
    tb_cmd[p] = 4'd0; tb_data[p] = b; cyc();
    tb_data[p] = $urandom; cyc();
    want = {1'b1, 2'(p), 31'b0, xe, xd, xo, xe};
    n_cmp++;
    if (res_v !== want || busy_v[p] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s result got %h busy %b want %h busy[%0d]=1", nm, res_v, busy_v, want, p);
    end
    cyc();
    n_cmp++;
    if (busy_v[p] !== 1'b0 || bus.prio_alu_out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_vld got busy %b vld %b want busy[%0d]=0 vld=0", nm, busy_v, bus.prio_alu_out_vld, p);
    end
  endtask

  task automatic test_single_ops();
    single_op(0, CMD_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, "p1_add");
    single_op(2, CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         1'b1, 1'b1, "p3_add_ovf");
    single_op(1, CMD_SUB, 32'h0000_0002, 32'h0000_0005, 32'h0,         1'b1, 1'b1, "p2_sub_borrow");
    single_op(1, CMD_SUB, 32'h0000_0009, 32'h0000_0004, 32'h0000_0005, 1'b0, 1'b0, "p2_sub");
    single_op(3, CMD_SHL, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 1'b0, 1'b0, "p4_shl");
    single_op(1, CMD_SHR, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, "p2_shr");
    single_op(0, 4'b0011, 32'h1234_5678, 32'h1,         32'h0,         1'b1, 1'b0, "p1_invalid");
  endtask

  task automatic test_all_ports();
    logic [68:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) begin tb_cmd[i] = CMD_ADD; tb_data[i] = 32'(i + 1); end
    cyc();
    for (int i = 0; i < 4; i++) begin tb_cmd[i] = 4'd0; tb_data[i] = 32'd100; end
    cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      want = {1'b1, 2'(k), 31'b0, 1'b0, 32'(101 + k), 1'b0, 1'b0};
      n_cmp++;
      if (res_v !== want) begin
        n_fail++;
        $display("FAIL rr_round1_%0d got %h want %h", k, res_v, want);
      end
    end
    cyc();
    n_cmp++;
    if (busy_v !== 4'd0 || bus.prio_alu_out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain got busy %b vld %b want 0 0", busy_v, bus.prio_alu_out_vld);
    end
    // Ports 2 and 1 together: pointer wrapped to 0, so port1 goes first.
    tb_cmd[1] = CMD_SUB; tb_data[1] = 32'd7;
    tb_cmd[0] = CMD_SUB; tb_data[0] = 32'd50;
    cyc();
    tb_cmd[1] = 4'd0; tb_data[1] = 32'd7;
    tb_cmd[0] = 4'd0; tb_data[0] = 32'd8;
    cyc(); cyc();
    want = {1'b1, 2'd0, 31'b0, 1'b0, 32'd42, 1'b0, 1'b0};
    n_cmp++;
    if (res_v !== want) begin n_fail++; $display("FAIL rr_round2_first got %h want %h", res_v, want); end
    cyc();
    want = {1'b1, 2'd1, 31'b0, 1'b0, 32'd0, 1'b0, 1'b0};
    n_cmp++;
    if (res_v !== want) begin n_fail++; $display("FAIL rr_round2_second got %h want %h", res_v, want); end
    cyc(); cyc();
  endtask

  task automatic test_reset_inflight();
    int nv;
    tb_cmd[1] = CMD_ADD; tb_data[1] = 32'd40; cyc();
    tb_cmd[1] = 4'd0;    tb_data[1] = 32'd2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (busy_v[1] !== 1'b0) begin n_fail++; $display("FAIL inflight_busy2 got %b want 0", busy_v[1]); end
    cyc();
    reset = 1'b1;
    nv = 0;
    repeat (5) begin cyc(); if (bus.prio_alu_out_vld) nv++; end
    n_cmp++;
    if (nv !== 0 || busy_v !== 4'd0) begin
      n_fail++;
      $display("FAIL inflight_no_vld got %0d vlds busy %b want 0 0", nv, busy_v);
    end
    single_op(1, CMD_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, "after_reset_p2");
    // Reset landing on a vld cycle clears the bus immediately.
    tb_cmd[0] = CMD_ADD; tb_data[0] = 32'd1; cyc();
    tb_cmd[0] = 4'd0;    tb_data[0] = 32'd1; cyc(); cyc();
    n_cmp++;
    if (bus.prio_alu_out_vld !== 1'b1) begin n_fail++; $display("FAIL async_pre_vld got 0 want 1"); end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (res_v !== 69'd0) begin n_fail++; $display("FAIL async_clear got %h want 0", res_v); end
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_busy_ignore();
    int nv;
    tb_cmd[0] = CMD_ADD; tb_data[0] = 32'd10; cyc();
    tb_cmd[0] = CMD_ADD; tb_data[0] = 32'd20; cyc();
    tb_cmd[0] = CMD_SUB; tb_data[0] = 32'd99; cyc();
    n_cmp++;
    if (res_v !== {1'b1, 2'd0, 31'b0, 1'b0, 32'd30, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL busy_ignore_result got %h want data 30 id 0", res_v);
    end
    cyc();
    tb_cmd[0] = 4'd0;
    nv = 0;
    repeat (6) begin
      if (bus.prio_alu_out_vld) nv++;
      cyc();
    end
    n_cmp++;
    if (nv !== 0 || busy_v !== 4'd0) begin
      n_fail++;
      $display("FAIL busy_ignore_extra got %0d vlds busy %b want 0 0", nv, busy_v);
    end
  endtask

  task automatic test_random();
    logic [3:0] cmds [8];
    cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd15};
    do_reset();
    n_cmp++;
    if (obs !== expv) begin n_fail++; $display("FAIL rand_start got %h want %h", obs, expv); end
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 4; i++) begin
        tb_cmd[i]  = ($urandom_range(0, 2) == 0) ? cmds[$urandom_range(0, 7)] : 4'd0;
        tb_data[i] = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      end
      cyc();
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL rand_cycle_%0d got %h want %h", t, obs, expv);
      end
    end
    idle_all();
    repeat (8) begin
      cyc();
      n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL rand_drain got %h want %h", obs, expv); end
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single_ops();
    test_all_ports();
    test_reset_inflight();
    test_busy_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
